// File: rtl/life_grid.sv
// life_grid: Conway's Life (B3/S23) on a ROWS x COLS register grid, edited with debounced buttons.
// Define LIFE_WRAP_EN for toroidal neighbours; by default cells beyond the edge count as dead.
module life_grid #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RATE = 60
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    btn_next,
  input  logic                    btn_toggle,
  input  logic                    btn_run,
  input  logic                    btn_pause,
  input  logic                    btn_step,
  input  logic                    frame_end,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic                    rd_state,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    running,
  output logic [15:0]             gen_count,
  output logic                    all_dead
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic {PAUSE, RUN} state_t;
  state_t state_q, state_d;

  logic [ROWS-1:0][COLS-1:0] cells, next_cells;
  logic [4:0] sync1, sync2, sync3, rise;
  logic       pause_e, run_e, step_e, toggle_e, next_e;
  logic [7:0] frame_cnt;
  logic       frame_gen, do_gen, do_toggle;

  // Buttons packed {pause, run, step, toggle, next}; sync3 exists only to find the rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {btn_pause, btn_run, btn_step, btn_toggle, btn_next};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise     = sync2 & ~sync3;
  assign pause_e  = rise[4];
  assign run_e    = rise[3] & ~rise[4];
  assign step_e   = rise[2] & ~|rise[4:3];
  assign toggle_e = rise[1] & ~|rise[4:2];
  assign next_e   = rise[0] & ~|rise[4:1];

  assign frame_gen = (state_q == RUN) && frame_end && (frame_cnt == 8'(RATE - 1));
  assign do_gen    = frame_gen || ((state_q == PAUSE) && step_e);
  assign do_toggle = (state_q == PAUSE) && toggle_e;

  always_ff @(posedge clock) begin
    if (reset || state_q == PAUSE) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_gen ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pause_e) begin
      state_d = PAUSE;
    end else if (run_e) begin
      state_d = RUN;
    end else if (frame_gen && next_cells == '0) begin
      state_d = PAUSE;
    end
  end

  assign running = (state_q == RUN);

  function automatic logic [3:0] live_neighbours(input logic [ROWS-1:0][COLS-1:0] g,
                                                 input int r, input int c);
    logic [3:0] n;
    n = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
`ifdef LIFE_WRAP_EN
          n = n + {3'd0, g[RW'((r + dr + ROWS) % ROWS)][CW'((c + dc + COLS) % COLS)]};
`else
          if (r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS) begin
            n = n + {3'd0, g[RW'(r + dr)][CW'(c + dc)]};
          end
`endif
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    next_cells = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        next_cells[r][c] = (live_neighbours(cells, r, c) == 4'd3) ||
                           (cells[r][c] && live_neighbours(cells, r, c) == 4'd2);
      end
    end
  end

  // A generation replaces the whole grid; toggle can only coincide with it in RUN, where it is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      cells <= '0;
    end else if (do_gen) begin
      cells <= next_cells;
    end else if (do_toggle) begin
      cells[cursor_row][cursor_col] <= ~cells[cursor_row][cursor_col];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gen_count <= '0;
    end else if (do_gen) begin
      gen_count <= gen_count + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cursor_row <= '0;
      cursor_col <= '0;
    end else if (next_e) begin
      if (cursor_col == CW'(COLS - 1)) begin
        cursor_col <= '0;
        cursor_row <= (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + 1'b1;
      end else begin
        cursor_col <= cursor_col + 1'b1;
      end
    end
  end

  // Decoded per cell so indices past a non-power-of-two edge read as 0.
  always_comb begin
    rd_state = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rd_row == RW'(r) && rd_col == CW'(c)) begin
          rd_state = cells[r][c];
        end
      end
    end
  end

  assign all_dead = (cells == '0);

endmodule
